// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Passive monitor for a multiplexed, active-low 4-digit seven-segment bus.
// It watches the segment lines and digit anodes, waits for each digit to
// settle, and decodes the lit pattern back into a hex nibble. Once all four
// digits have been captured, it publishes the 16-bit value together with
// per-digit error and blank flags.
//
// Parameters:
//   STABLE_CYCLES  matching samples required after the first one before an
//                  (anode, segment) pair is captured (legal range 1..255)
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        synchronous active-low reset
//   seg[6:0]     segment lines, active-low, bit0=a .. bit6=g
//   an[3:0]      digit anodes, active-low, an[i]=0 selects digit i
//   value[15:0]  last completed frame, digit i in bits [4i+3:4i]
//   digit_err    bit i set if digit i held an undecodable pattern
//   digit_blank  bit i set if digit i was fully dark
//   frame_valid  one-cycle pulse when the three outputs above update
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic [3:0]  digit_blank,
  output logic        frame_valid
);

  // The counter only has to reach STABLE_CYCLES, so it is sized to hold
  // exactly that value.
  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Previous-cycle copy of the pins, used to detect a constant dwell.
  logic [3:0]       s_an;
  logic [6:0]       s_seg;
  logic [CNT_W-1:0] cnt;

  // Partially assembled frame.
  logic [15:0] stage_val;
  logic [3:0]  stage_err;
  logic [3:0]  stage_blank;
  logic [3:0]  mask;

  // Decoded view of the current pins.
  logic [3:0]  dec_nibble;
  logic        dec_err;
  logic        dec_blank;
  logic        sel_valid;
  logic [1:0]  sel_idx;

  logic        pins_stable;
  logic        capture;
  logic        frame_done;

  // Staging data with the current capture merged in.
  logic [15:0] merged_val;
  logic [3:0]  merged_err;
  logic [3:0]  merged_blank;
  logic [3:0]  merged_mask;

  // Inverse of the hex-to-seven-segment encoder. Patterns are written g..a
  // so they line up with the seg bus bit order.
  always_comb begin
    dec_nibble = 4'h0;
    dec_err    = 1'b0;
    dec_blank  = 1'b0;
    case (seg)
      7'b1000000: dec_nibble = 4'h0;
      7'b1111001: dec_nibble = 4'h1;
      7'b0100100: dec_nibble = 4'h2;
      7'b0110000: dec_nibble = 4'h3;
      7'b0011001: dec_nibble = 4'h4;
      7'b0010010: dec_nibble = 4'h5;
      7'b0000010: dec_nibble = 4'h6;
      7'b1111000: dec_nibble = 4'h7;
      7'b0000000: dec_nibble = 4'h8;
      7'b0010000: dec_nibble = 4'h9;
      7'b0001000: dec_nibble = 4'hA;
      7'b0000011: dec_nibble = 4'hB;
      7'b1000110: dec_nibble = 4'hC;
      7'b0100001: dec_nibble = 4'hD;
      7'b0000110: dec_nibble = 4'hE;
      7'b0001110: dec_nibble = 4'hF;
      7'b1111111: dec_blank  = 1'b1;
      default:    dec_err    = 1'b1;
    endcase
  end

  // Only a single low anode names a digit. Blanking (all high) and
  // overlapping anodes are legal bus states, but they are never captured.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (an)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  // A capture happens on the edge where the counter steps onto its
  // saturation value. A saturated counter never steps again, so a long
  // dwell produces exactly one capture.
  assign pins_stable = sel_valid && (an == s_an) && (seg == s_seg);
  assign capture     = pins_stable && (cnt == CNT_PRE);

  // Fold the digit being captured into the staging copy so a completing
  // digit reaches the outputs on the same edge.
  always_comb begin
    merged_val   = stage_val;
    merged_err   = stage_err;
    merged_blank = stage_blank;
    merged_mask  = mask;
    if (capture) begin
      merged_val[{sel_idx, 2'b00} +: 4] = dec_nibble;
      merged_err[sel_idx]               = dec_err;
      merged_blank[sel_idx]             = dec_blank;
      merged_mask[sel_idx]              = 1'b1;
    end
  end

  assign frame_done = capture && (merged_mask == 4'b1111);

  // Pin sampling, dwell counting, and frame assembly. All of it restarts
  // from scratch on reset, so a partial frame is never reused afterward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_an        <= 4'b1111;
      s_seg       <= 7'b1111111;
      cnt         <= '0;
      stage_val   <= 16'h0000;
      stage_err   <= 4'b0000;
      stage_blank <= 4'b0000;
      mask        <= 4'b0000;
      value       <= 16'h0000;
      digit_err   <= 4'b0000;
      digit_blank <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      s_an  <= an;
      s_seg <= seg;

      if (pins_stable) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end

      stage_val   <= merged_val;
      stage_err   <= merged_err;
      stage_blank <= merged_blank;
      frame_valid <= frame_done;

      if (frame_done) begin
        value       <= merged_val;
        digit_err   <= merged_err;
        digit_blank <= merged_blank;
        mask        <= 4'b0000;
      end else begin
        mask        <= merged_mask;
      end
    end
  end

endmodule
